// File: rtl/inst_queue_if.sv
// Fetch-to-decode instruction queue bundle.
// Handshake: an entry moves on a rising edge when its valid and ready are both
// high in that cycle and flush is low; valid must not wait on ready, and ready
// on the fetch side depends only on queue occupancy.
interface inst_queue_if #(
    parameter int DEPTH = 4
);
    logic                     flush;
    logic                     in_valid;
    logic [63:0]              in_pc;
    logic [31:0]              in_instr;
    logic                     in_ready;
    logic                     out_valid;
    logic [63:0]              out_pc;
    logic [31:0]              out_instr;
    logic                     out_misalign;
    logic                     out_ready;
    logic [$clog2(DEPTH):0]   count;

    // Driver side: fetch, decode and the redirect source.
    modport master (
        output flush, in_valid, in_pc, in_instr, out_ready,
        input  in_ready, out_valid, out_pc, out_instr, out_misalign, count
    );

    // Queue side.
    modport slave (
        input  flush, in_valid, in_pc, in_instr, out_ready,
        output in_ready, out_valid, out_pc, out_instr, out_misalign, count
    );
endinterface

// File: rtl/inst_queue.sv
// Decoupling FIFO between fetch and decode: circular buffer with a separate
// occupancy counter, no bypass, and a redirect flush that drops all entries.
module inst_queue #(
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    inst_queue_if.slave   bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        misalign;
    } entry_t;

    entry_t        mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    // Full blocks a push even when the head pops in the same cycle, so
    // in_ready never depends on out_ready.
    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);
    assign push  = bus.in_valid & ~full & ~bus.flush;
    assign pop   = ~empty & bus.out_ready & ~bus.flush;

    assign bus.in_ready     = ~full;
    assign bus.out_valid    = ~empty;
    assign bus.out_pc       = mem_q[rd_ptr_q].pc;
    assign bus.out_instr    = mem_q[rd_ptr_q].instr;
    assign bus.out_misalign = mem_q[rd_ptr_q].misalign;
    assign bus.count        = count_q;

    // Next pointer/occupancy; flush overrides any push or pop this cycle.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (push && !pop)      count_d = count_q + CNT_ONE;
            else if (pop && !push) count_d = count_q - CNT_ONE;
        end
    end

    // Control state, cleared asynchronously; entry contents are never cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry write on an accepted push; misalign captured from the low PC bits.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q].pc       <= bus.in_pc;
            mem_q[wr_ptr_q].instr    <= bus.in_instr;
            mem_q[wr_ptr_q].misalign <= (bus.in_pc[1:0] != 2'b00);
        end
    end
endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: directed scenarios followed by random
// traffic, all compared against a queue-based model of the FIFO.
module tb_inst_queue;
    localparam int DEPTH = 4;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   violations;

    // Model contents: {pc, instr} per buffered entry, head at index 0.
    logic [95:0] exp_q[$];

    inst_queue_if #(.DEPTH(DEPTH)) q_if ();

    inst_queue #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (q_if.slave)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Compare outputs with the model, apply this cycle's inputs to the model,
    // then advance to the next falling edge.
    task automatic cycle();
        int          sz;
        logic [95:0] head;
        logic        full;
        sz   = exp_q.size();
        full = (sz >= DEPTH);
        check("out_valid", 64'(q_if.out_valid), 64'(sz != 0));
        check("count",     64'(q_if.count),     64'(sz));
        check("in_ready",  64'(q_if.in_ready),  64'(!full));
        if (sz != 0) begin
            head = exp_q[0];
            check("out_pc",       q_if.out_pc,              head[95:32]);
            check("out_instr",    64'(q_if.out_instr),      64'(head[31:0]));
            check("out_misalign", 64'(q_if.out_misalign),   64'(head[33:32] != 2'b00));
        end
        if (q_if.flush) begin
            exp_q.delete();
        end else begin
            if (q_if.in_valid && full) violations++;
            if (sz != 0 && q_if.out_ready) void'(exp_q.pop_front());
            if (q_if.in_valid && !full) exp_q.push_back({q_if.in_pc, q_if.in_instr});
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic v, input logic [63:0] pc, input logic [31:0] instr,
                         input logic ordy, input logic fl);
        q_if.in_valid  = v;
        q_if.in_pc     = pc;
        q_if.in_instr  = instr;
        q_if.out_ready = ordy;
        q_if.flush     = fl;
        cycle();
    endtask

    task automatic idle(input logic ordy);
        drive(1'b0, 64'h0, 32'h0, ordy, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 1; i++) idle(1'b1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [63:0] exp_pc [4];
        checks     = 0;
        errors     = 0;
        violations = 0;
        rst        = 1'b0;
        q_if.in_valid  = 1'b0;
        q_if.in_pc     = 64'h0;
        q_if.in_instr  = 32'h0;
        q_if.out_ready = 1'b0;
        q_if.flush     = 1'b0;

        // Power-on reset, checked before any clock edge.
        #1 rst = 1'b1;
        #2;
        check("rst_out_valid", 64'(q_if.out_valid), 64'd0);
        check("rst_count",     64'(q_if.count),     64'd0);
        check("rst_in_ready",  64'(q_if.in_ready),  64'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Single pass: visible one cycle after push, gone after the pop.
        drive(1'b1, 64'h8000_0000, 32'h0000_0013, 1'b1, 1'b0);
        check("single_valid", 64'(q_if.out_valid), 64'd1);
        check("single_pc",    q_if.out_pc,         64'h8000_0000);
        check("single_instr", 64'(q_if.out_instr), 64'h13);
        idle(1'b1);
        check("single_gone",  64'(q_if.out_valid), 64'd0);

        // Fill to DEPTH, pop two, push two more across the pointer wrap.
        for (int i = 0; i < 4; i++)
            drive(1'b1, 64'h1000 + 64'(4 * i), 32'h100 + 32'(i), 1'b0, 1'b0);
        check("fill_count", 64'(q_if.count),    64'd4);
        check("fill_ready", 64'(q_if.in_ready), 64'd0);
        idle(1'b1);
        idle(1'b1);
        drive(1'b1, 64'h1010, 32'h104, 1'b0, 1'b0);
        drive(1'b1, 64'h1014, 32'h105, 1'b0, 1'b0);
        exp_pc[0] = 64'h1008; exp_pc[1] = 64'h100C;
        exp_pc[2] = 64'h1010; exp_pc[3] = 64'h1014;
        for (int i = 0; i < 4; i++) begin
            check("wrap_order", q_if.out_pc, exp_pc[i]);
            idle(1'b1);
        end
        check("wrap_empty", 64'(q_if.out_valid), 64'd0);

        // Simultaneous push/pop at count 2, then pop while full.
        drive(1'b1, 64'h3000, 32'h1, 1'b0, 1'b0);
        drive(1'b1, 64'h3004, 32'h2, 1'b0, 1'b0);
        drive(1'b1, 64'h3008, 32'h3, 1'b1, 1'b0);
        check("pp_count", 64'(q_if.count), 64'd2);
        check("pp_head",  q_if.out_pc,     64'h3004);
        drive(1'b1, 64'h300C, 32'h4, 1'b0, 1'b0);
        drive(1'b1, 64'h3010, 32'h5, 1'b0, 1'b0);
        check("full_count", 64'(q_if.count), 64'd4);
        drive(1'b1, 64'h3014, 32'h6, 1'b1, 1'b0);
        check("fullpop_count", 64'(q_if.count),    64'd3);
        check("fullpop_ready", 64'(q_if.in_ready), 64'd1);
        check("fullpop_head",  q_if.out_pc,        64'h3008);
        drain();

        // Flush beats a same-cycle push and pop.
        for (int i = 0; i < 3; i++)
            drive(1'b1, 64'h4000 + 64'(4 * i), 32'h40 + 32'(i), 1'b0, 1'b0);
        drive(1'b1, 64'hDEAD_0000, 32'hDEAD, 1'b1, 1'b1);
        check("flush_count", 64'(q_if.count),     64'd0);
        check("flush_valid", 64'(q_if.out_valid), 64'd0);
        check("flush_ready", 64'(q_if.in_ready),  64'd1);
        drive(1'b1, 64'h2000, 32'h0000_0093, 1'b0, 1'b0);
        check("post_flush_pc",    q_if.out_pc,     64'h2000);
        check("post_flush_count", 64'(q_if.count), 64'd1);
        drain();

        // Misaligned PC and back-pressure stability.
        drive(1'b1, 64'h8000_0002, 32'h1234_5678, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check("misalign",     64'(q_if.out_misalign), 64'd1);
            check("hold_pc",      q_if.out_pc,            64'h8000_0002);
            check("hold_instr",   64'(q_if.out_instr),    64'h1234_5678);
            idle(1'b0);
        end
        drain();

        // Asynchronous reset mid-cycle with two entries queued.
        drive(1'b1, 64'h5000, 32'h50, 1'b0, 1'b0);
        drive(1'b1, 64'h5004, 32'h51, 1'b0, 1'b0);
        check("pre_rst_count", 64'(q_if.count), 64'd2);
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid", 64'(q_if.out_valid), 64'd0);
        check("async_rst_count", 64'(q_if.count),     64'd0);
        check("async_rst_ready", 64'(q_if.in_ready),  64'd1);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 3) != 0,
                  {32'h0, $urandom()},
                  $urandom(),
                  $urandom_range(0, 2) != 0,
                  $urandom_range(0, 31) == 0);
        end

        $display("note: in_valid while full (dropped): %0d", violations);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
